// File: rtl/wb_commit_unit.sv
// Writeback stage: commits ALU results directly and runs load transactions
// (request/ack, lane extraction, extension) before driving the register file write port.
module wb_commit_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_write,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_funct3,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        rf_write,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    output logic        wb_err,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StWaitAck, StCommit} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        write_q, write_d;
    logic        rf_write_q, rf_write_d;
    logic [4:0]  rf_rd_q, rf_rd_d;
    logic [31:0] rf_data_q, rf_data_d;
    logic        dmem_req_q, dmem_req_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic        wb_err_q, wb_err_d;

    logic        f3_legal, misaligned, timeout;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    always_comb begin
        f3_legal   = 1'b1;
        misaligned = 1'b0;
        case (ex_funct3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = ex_result[0];
            3'b010:         misaligned = |ex_result[1:0];
            default:        f3_legal   = 1'b0;
        endcase
    end

    always_comb begin
        byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    assign timeout = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        write_d     = write_q;
        rf_write_d  = 1'b0;
        rf_rd_d     = rf_rd_q;
        rf_data_d   = rf_data_q;
        dmem_req_d  = dmem_req_q;
        dmem_addr_d = dmem_addr_q;
        wb_err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    if (!ex_is_load) begin
                        rf_write_d = ex_write & (ex_rd != 5'd0);
                        rf_rd_d    = ex_rd;
                        rf_data_d  = ex_result;
                    end else if (!f3_legal || misaligned) begin
                        wb_err_d = 1'b1;
                    end else begin
                        rd_d        = ex_rd;
                        funct3_d    = ex_funct3;
                        off_d       = ex_result[1:0];
                        write_d     = ex_write;
                        dmem_req_d  = 1'b1;
                        dmem_addr_d = {ex_result[31:2], 2'b00};
                        cnt_d       = 8'd0;
                        state_d     = StWaitAck;
                    end
                end
            end
            StWaitAck: begin
                cnt_d = cnt_q + 8'd1;
                // Ack takes priority over a timeout landing in the same cycle.
                if (dmem_ack) begin
                    rf_write_d = write_q & (rd_q != 5'd0);
                    rf_rd_d    = rd_q;
                    rf_data_d  = load_data;
                    dmem_req_d = 1'b0;
                    state_d    = StCommit;
                end else if (timeout) begin
                    dmem_req_d = 1'b0;
                    wb_err_d   = 1'b1;
                    state_d    = StIdle;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            rd_q        <= 5'd0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            write_q     <= 1'b0;
            rf_write_q  <= 1'b0;
            rf_rd_q     <= 5'd0;
            rf_data_q   <= 32'd0;
            dmem_req_q  <= 1'b0;
            dmem_addr_q <= 32'd0;
            wb_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            write_q     <= write_d;
            rf_write_q  <= rf_write_d;
            rf_rd_q     <= rf_rd_d;
            rf_data_q   <= rf_data_d;
            dmem_req_q  <= dmem_req_d;
            dmem_addr_q <= dmem_addr_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign ex_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rf_write  = rf_write_q;
    assign rf_rd     = rf_rd_q;
    assign rf_data   = rf_data_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_addr = dmem_addr_q;
    assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit with TIMEOUT_CYCLES=4; expected values are hand-computed.
module tb_wb_commit_unit;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_write = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic [31:0] ex_result = 32'd0;
    logic        ex_is_load = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        rf_write;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        wb_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    wb_commit_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_write   (ex_write),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .ex_is_load (ex_is_load),
        .ex_funct3  (ex_funct3),
        .dmem_req   (dmem_req),
        .dmem_addr  (dmem_addr),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .rf_write   (rf_write),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data),
        .wb_err     (wb_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs and outputs are handled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] res,
                         input logic ld, input logic [2:0] f3);
        ex_valid   = v;
        ex_write   = w;
        ex_rd      = rd;
        ex_result  = res;
        ex_is_load = ld;
        ex_funct3  = f3;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input int delay, input logic [31:0] exp);
        drive(1'b1, 1'b1, 5'd5, addr, 1'b1, f3);
        tick();
        ex_valid = 1'b0;
        check_eq({tag, "_req"}, 32'(dmem_req), 32'd1);
        check_eq({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check_eq({tag, "_ready"}, 32'(ex_ready), 32'd0);
        repeat (delay) tick();
        check_eq({tag, "_nowrite"}, 32'(rf_write), 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_ack = 1'b0;
        check_eq({tag, "_wr"}, 32'(rf_write), 32'd1);
        check_eq({tag, "_rd"}, 32'(rf_rd), 32'd5);
        check_eq({tag, "_data"}, rf_data, exp);
        check_eq({tag, "_err"}, 32'(wb_err), 32'd0);
        check_eq({tag, "_reqoff"}, 32'(dmem_req), 32'd0);
        tick();
        check_eq({tag, "_wr1"}, 32'(rf_write), 32'd0);
        check_eq({tag, "_idle"}, 32'(ex_ready), 32'd1);
    endtask

    task automatic bad_load(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        drive(1'b1, 1'b1, 5'd6, addr, 1'b1, f3);
        tick();
        ex_valid = 1'b0;
        check_eq({tag, "_err"}, 32'(wb_err), 32'd1);
        check_eq({tag, "_req"}, 32'(dmem_req), 32'd0);
        check_eq({tag, "_wr"}, 32'(rf_write), 32'd0);
        check_eq({tag, "_ready"}, 32'(ex_ready), 32'd1);
        tick();
        check_eq({tag, "_err1"}, 32'(wb_err), 32'd0);
    endtask

    initial begin
        int cnt;

        // 1. Reset in the middle of a load
        #12 nrst = 1'b1;
        tick();
        drive(1'b1, 1'b1, 5'd5, 32'h200, 1'b1, 3'b010);
        tick();
        ex_valid = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd1);
        tick();
        #2 nrst = 1'b0;
        #1;
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_addr", dmem_addr, 32'd0);
        check_eq("rst_busy0", 32'(busy), 32'd0);
        check_eq("rst_rfw", 32'(rf_write), 32'd0);
        check_eq("rst_rfrd", 32'(rf_rd), 32'd0);
        check_eq("rst_rfdata", rf_data, 32'd0);
        check_eq("rst_err", 32'(wb_err), 32'd0);
        tick();
        #2 nrst = 1'b1;
        check_eq("rst_ready", 32'(ex_ready), 32'd1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        tick();
        check_eq("rst_nowrite", 32'(rf_write), 32'd0);
        check_eq("rst_noerr", 32'(wb_err), 32'd0);
        drive(1'b1, 1'b1, 5'd1, 32'd1, 1'b0, 3'b000);
        tick();
        ex_valid = 1'b0;
        check_eq("alu1_wr", 32'(rf_write), 32'd1);
        check_eq("alu1_rd", 32'(rf_rd), 32'd1);
        check_eq("alu1_data", rf_data, 32'd1);
        tick();
        check_eq("alu1_wr1", 32'(rf_write), 32'd0);

        // 2. Back-to-back ALU results
        drive(1'b1, 1'b1, 5'd1, 32'h1, 1'b0, 3'b000);
        tick();
        check_eq("b2b_wr1", 32'(rf_write), 32'd1);
        check_eq("b2b_rd1", 32'(rf_rd), 32'd1);
        check_eq("b2b_d1", rf_data, 32'h1);
        drive(1'b1, 1'b1, 5'd2, 32'h2, 1'b0, 3'b000);
        tick();
        check_eq("b2b_wr2", 32'(rf_write), 32'd1);
        check_eq("b2b_rd2", 32'(rf_rd), 32'd2);
        check_eq("b2b_d2", rf_data, 32'h2);
        drive(1'b1, 1'b1, 5'd0, 32'hFF, 1'b0, 3'b000);
        tick();
        check_eq("b2b_x0", 32'(rf_write), 32'd0);
        check_eq("b2b_ready", 32'(ex_ready), 32'd1);
        drive(1'b1, 1'b0, 5'd3, 32'h3, 1'b0, 3'b000);
        tick();
        ex_valid = 1'b0;
        check_eq("b2b_nowr", 32'(rf_write), 32'd0);
        check_eq("b2b_ready2", 32'(ex_ready), 32'd1);

        // 3/4. Loads with extraction and extension
        run_load("lb", 3'b000, 32'h103, 32'h80112233, 2, 32'hFFFFFF80);
        run_load("lbu", 3'b100, 32'h103, 32'h80112233, 2, 32'h00000080);
        run_load("lh", 3'b001, 32'h202, 32'h9ABC1234, 1, 32'hFFFF9ABC);
        run_load("lhu", 3'b101, 32'h202, 32'h9ABC1234, 0, 32'h00009ABC);
        run_load("lw", 3'b010, 32'h200, 32'h9ABC1234, 1, 32'h9ABC1234);
        run_load("lbu1", 3'b100, 32'h301, 32'hA1B2C3D4, 0, 32'h000000C3);

        // 5. Error cases
        bad_load("mis_lw", 3'b010, 32'h201);
        bad_load("mis_lh", 3'b001, 32'h203);
        bad_load("ill_f3", 3'b011, 32'h200);
        drive(1'b1, 1'b1, 5'd7, 32'h400, 1'b1, 3'b010);
        tick();
        ex_valid = 1'b0;
        cnt = 0;
        while (dmem_req && cnt < 10) begin
            cnt++;
            check_eq("to_noerr", 32'(wb_err), 32'd0);
            tick();
        end
        check_eq("to_reqcycles", 32'(cnt), 32'd4);
        check_eq("to_err", 32'(wb_err), 32'd1);
        check_eq("to_wr", 32'(rf_write), 32'd0);
        check_eq("to_idle", 32'(busy), 32'd0);
        tick();
        check_eq("to_err1", 32'(wb_err), 32'd0);

        // 6. Ack on the timeout cycle, with a pending ALU op held during busy
        drive(1'b1, 1'b1, 5'd9, 32'h202, 1'b1, 3'b001);
        tick();
        drive(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 3'b000);
        repeat (3) tick();
        check_eq("edge_wait", 32'(dmem_req), 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h7FFF0000;
        tick();
        dmem_ack = 1'b0;
        check_eq("edge_err", 32'(wb_err), 32'd0);
        check_eq("edge_wr", 32'(rf_write), 32'd1);
        check_eq("edge_rd", 32'(rf_rd), 32'd9);
        check_eq("edge_data", rf_data, 32'h00007FFF);
        check_eq("edge_commit_rdy", 32'(ex_ready), 32'd0);
        tick();
        check_eq("edge_wr1", 32'(rf_write), 32'd0);
        check_eq("edge_err1", 32'(wb_err), 32'd0);
        check_eq("edge_rdy", 32'(ex_ready), 32'd1);
        tick();
        ex_valid = 1'b0;
        check_eq("held_wr", 32'(rf_write), 32'd1);
        check_eq("held_rd", 32'(rf_rd), 32'd7);
        check_eq("held_data", rf_data, 32'h77);
        tick();
        check_eq("held_wr1", 32'(rf_write), 32'd0);

        // Stray ack in IDLE does nothing
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        tick();
        check_eq("stray_wr", 32'(rf_write), 32'd0);
        check_eq("stray_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
